// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: byte-side handshake bundle of the configurable UART receiver.
//   rx_data        word received, LSB first on the line
//   rx_data_valid  rx_data and the error flags are valid
//   rx_data_ready  consumer takes the word when high together with rx_data_valid
//   parity_err     parity mismatch on the held word
//   frame_err      a stop-bit sample was 0 on the held word
//   overrun        one-cycle pulse when a completed frame was dropped
// Handshake: a word moves on every clk edge where rx_data_valid && rx_data_ready.
// rx_data_valid may rise at any time, and once high it stays high with rx_data
// and the flags held stable until that transfer edge.
// modport master = receiver side, modport slave = consumer side.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 rx_data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_data_valid, parity_err, frame_err, overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data, rx_data_valid, parity_err, frame_err, overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits). Each bit is decided by majority vote of three
// samples taken just before and at the bit centre. A start bit that votes 1
// is treated as noise. The receiver keeps running while the consumer stalls.
// If a frame completes while the previous word is still held, the new frame
// is dropped and overrun pulses.
// Ports:
//   clk        single clock
//   rst_n      synchronous active-low reset
//   rx_pin     asynchronous serial input, idle high
//   bus        uart_rx_cfg_if.master (rx_data/valid/ready, error flags, overrun)
//   dbg_state  current receiver state (state_t encoding)
// CLK_FRE*1000000/BAUD_RATE must be at least 6.
module uart_rx_cfg #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  uart_rx_cfg_if.master        bus,
  output logic [2:0]           dbg_state
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int MID   = CYCLE / 2 - 1;

  localparam logic [15:0] CNT_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] CNT_MID  = 16'(MID);
  localparam logic [15:0] CNT_S1   = 16'(MID - 2);
  localparam logic [15:0] CNT_S2   = 16'(MID - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [15:0]          cnt, cnt_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic [DATA_BITS-1:0] rx_bits, rx_bits_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 ferr, ferr_nxt;
  logic                 done;
  logic                 done_ferr;

  logic sync1, sync2, sync_d;
  logic smp1, smp2;
  logic fall, vote, at_mid, at_last;
  logic par_err_calc;

  assign dbg_state = state;

  // Two-flop synchroniser plus one delay stage for the falling-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= rx_pin;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign fall    = sync_d & ~sync2;
  assign at_mid  = (cnt == CNT_MID);
  assign at_last = (cnt == CNT_LAST);

  // The first two samples are stored. The third sample is the live
  // synchronised value in the MID cycle, so the vote is ready at MID itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp1 <= 1'b0;
      smp2 <= 1'b0;
    end else begin
      if (cnt == CNT_S1) smp1 <= sync2;
      if (cnt == CNT_S2) smp2 <= sync2;
    end
  end

  assign vote = (smp1 & smp2) | (smp1 & sync2) | (smp2 & sync2);

  // ^rx_bits is 1 for an odd count of ones in the data.
  always_comb begin
    par_err_calc = 1'b0;
    if (PARITY == 1)      par_err_calc = ~(^rx_bits ^ par_bit);
    else if (PARITY == 2) par_err_calc = ^rx_bits ^ par_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 16'd0;
      bit_cnt  <= 4'd0;
      stop_cnt <= 1'b0;
      rx_bits  <= '0;
      par_bit  <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      rx_bits  <= rx_bits_nxt;
      par_bit  <= par_bit_nxt;
      ferr     <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 16'd1;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    rx_bits_nxt  = rx_bits;
    par_bit_nxt  = par_bit;
    ferr_nxt     = ferr;
    done         = 1'b0;
    done_ferr    = ferr | ~vote;
    case (state)
      S_IDLE: begin
        cnt_nxt = 16'd0;
        if (fall) begin
          state_nxt    = S_START;
          bit_cnt_nxt  = 4'd0;
          stop_cnt_nxt = 1'b0;
          ferr_nxt     = 1'b0;
        end
      end
      S_START: begin
        if (at_mid && vote) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 16'd0;
        end else if (at_last) begin
          state_nxt = S_DATA;
          cnt_nxt   = 16'd0;
        end
      end
      S_DATA: begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (at_mid && bit_cnt == 4'(i)) rx_bits_nxt[i] = vote;
        end
        if (at_last) begin
          cnt_nxt = 16'd0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (at_mid) par_bit_nxt = vote;
        if (at_last) begin
          state_nxt = S_STOP;
          cnt_nxt   = 16'd0;
        end
      end
      S_STOP: begin
        if (at_mid) begin
          ferr_nxt = done_ferr;
          // Finishing at the centre of the last stop bit leaves half a bit
          // to catch a following start edge with no dead time.
          if (stop_cnt == STOP_LAST) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = 16'd0;
          end
        end else if (at_last) begin
          stop_cnt_nxt = stop_cnt + 1'b1;
          cnt_nxt      = 16'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Output holding register. A completion in the same cycle as a transfer
  // reloads it, so the consumer never loses a word to that collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rx_data       <= '0;
      bus.rx_data_valid <= 1'b0;
      bus.parity_err    <= 1'b0;
      bus.frame_err     <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.overrun <= 1'b0;
      if (done) begin
        if (!bus.rx_data_valid || bus.rx_data_ready) begin
          bus.rx_data       <= rx_bits;
          bus.parity_err    <= par_err_calc;
          bus.frame_err     <= done_ferr;
          bus.rx_data_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.rx_data_valid && bus.rx_data_ready) begin
        bus.rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg with CYCLE=8, MID=3.
// Three instances: a = 8N1, b = 7 data bits even parity, c = 8 data bits, 2 stop bits.
// Frames are driven one pin cycle at a time. A negedge monitor records
// valid rises, transfers and overrun pulses. Each test task checks against
// hand-computed values.
module tb_uart_rx_cfg;

  logic clk;
  logic rst_n;
  logic pin_a, pin_b, pin_c;
  logic [2:0] st_a, st_b, st_c;
  int cyc;
  int errors;
  int checks;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_cfg_if #(.DATA_BITS(7)) bus_b ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus_c ();

  uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(125000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .rx_pin(pin_a), .bus(bus_a), .dbg_state(st_a));
  uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(125000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
    dut_b (.clk(clk), .rst_n(rst_n), .rx_pin(pin_b), .bus(bus_b), .dbg_state(st_b));
  uart_rx_cfg #(.CLK_FRE(1), .BAUD_RATE(125000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    dut_c (.clk(clk), .rst_n(rst_n), .rx_pin(pin_c), .bus(bus_c), .dbg_state(st_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  logic [8:0] m_data [3];
  logic [2:0] m_v, m_r, m_pe, m_fe, m_ov;
  assign m_data[0] = {1'b0, bus_a.rx_data};
  assign m_data[1] = {2'b00, bus_b.rx_data};
  assign m_data[2] = {1'b0, bus_c.rx_data};
  assign m_v  = {bus_c.rx_data_valid, bus_b.rx_data_valid, bus_a.rx_data_valid};
  assign m_r  = {bus_c.rx_data_ready, bus_b.rx_data_ready, bus_a.rx_data_ready};
  assign m_pe = {bus_c.parity_err, bus_b.parity_err, bus_a.parity_err};
  assign m_fe = {bus_c.frame_err, bus_b.frame_err, bus_a.frame_err};
  assign m_ov = {bus_c.overrun, bus_b.overrun, bus_a.overrun};

  int rise_cnt [3];
  int hi_cnt [3];
  int xfer_cnt [3];
  int ovr_cnt [3];
  int rise_cyc [3];
  int ovr_cyc [3];
  logic [8:0] cap_data [3];
  logic [2:0] cap_pe, cap_fe, v_prev;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rise_cnt[i] = 0; hi_cnt[i] = 0; xfer_cnt[i] = 0; ovr_cnt[i] = 0;
      rise_cyc[i] = 0; ovr_cyc[i] = 0; cap_data[i] = '0;
    end
    cap_pe = '0; cap_fe = '0; v_prev = '0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_v[i] && !v_prev[i]) begin
        rise_cnt[i] <= rise_cnt[i] + 1;
        rise_cyc[i] <= cyc;
        cap_data[i] <= m_data[i];
        cap_pe[i]   <= m_pe[i];
        cap_fe[i]   <= m_fe[i];
      end
      if (m_v[i]) hi_cnt[i] <= hi_cnt[i] + 1;
      if (m_v[i] && m_r[i]) xfer_cnt[i] <= xfer_cnt[i] + 1;
      if (m_ov[i]) begin
        ovr_cnt[i] <= ovr_cnt[i] + 1;
        ovr_cyc[i] <= cyc;
      end
      v_prev[i] <= m_v[i];
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pin(input int w, input logic v);
    case (w)
      0:       pin_a = v;
      1:       pin_b = v;
      default: pin_c = v;
    endcase
  endtask

  // bits[0] is the start bit. Each bit lasts 8 clocks. glitch flips one pin
  // cycle; rst_at pulls rst_n low for one cycle (-1 disables either).
  task automatic send_frame(input int w, input logic [15:0] bits, input int n,
                            input int glitch, input int rst_at, output int c0);
    logic b;
    c0 = cyc;
    for (int i = 0; i < n * 8; i++) begin
      b = bits[4'(i / 8)];
      set_pin(w, (i == glitch) ? ~b : b);
      rst_n = (i == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    set_pin(w, 1'b1);
    rst_n = 1'b1;
  endtask

  // tests
  task automatic test_reset;
    rst_n = 1'b0;
    pin_a = 1'b1; pin_b = 1'b1; pin_c = 1'b1;
    bus_a.rx_data_ready = 1'b0;
    bus_b.rx_data_ready = 1'b0;
    bus_c.rx_data_ready = 1'b0;
    idle(3);
    checks++;
    if ({bus_a.rx_data, bus_a.rx_data_valid, bus_a.parity_err, bus_a.frame_err, bus_a.overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_a_outputs: got %h want 000",
               {bus_a.rx_data, bus_a.rx_data_valid, bus_a.parity_err, bus_a.frame_err, bus_a.overrun});
    end
    checks++;
    if ({bus_b.rx_data_valid, bus_c.rx_data_valid, bus_b.rx_data, bus_c.rx_data} !== 17'h0) begin
      errors++;
      $display("FAIL reset_bc_outputs: got %h want 0",
               {bus_b.rx_data_valid, bus_c.rx_data_valid, bus_b.rx_data, bus_c.rx_data});
    end
    rst_n = 1'b1;
    idle(4);
    checks++;
    if ({st_a, st_b, st_c} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state_idle: got %h want 0", {st_a, st_b, st_c});
    end
    checks++;
    if (bus_a.rx_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_after_release: got %b want 0", bus_a.rx_data_valid);
    end
  endtask

  task automatic test_basic;
    int c0, r0, h0;
    bus_a.rx_data_ready = 1'b1;
    r0 = rise_cnt[0]; h0 = hi_cnt[0];
    send_frame(0, {1'b1, 8'h55, 1'b0}, 10, -1, -1, c0);
    idle(20);
    checks++;
    if (rise_cnt[0] - r0 !== 1) begin
      errors++; $display("FAIL basic_deliveries: got %0d want 1", rise_cnt[0] - r0);
    end
    checks++;
    if (cap_data[0] !== 9'h055) begin
      errors++; $display("FAIL basic_data: got %h want 055", cap_data[0]);
    end
    checks++;
    if ({cap_pe[0], cap_fe[0]} !== 2'b00) begin
      errors++; $display("FAIL basic_flags: got %b want 00", {cap_pe[0], cap_fe[0]});
    end
    checks++;
    if (hi_cnt[0] - h0 !== 1) begin
      errors++; $display("FAIL basic_valid_cycles: got %0d want 1", hi_cnt[0] - h0);
    end
    // pin fall + 3 (sync + edge detect) + 9*8 + 3 + 1
    checks++;
    if (rise_cyc[0] - c0 !== 79) begin
      errors++; $display("FAIL basic_latency: got %0d want 79", rise_cyc[0] - c0);
    end
  endtask

  task automatic test_parity;
    int c0;
    bus_b.rx_data_ready = 1'b1;
    // 0x41 has two ones, so even parity wants p=0; send p=1 first.
    send_frame(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10, -1, -1, c0);
    idle(20);
    checks++;
    if (cap_data[1] !== 9'h041) begin
      errors++; $display("FAIL parity_bad_data: got %h want 041", cap_data[1]);
    end
    checks++;
    if ({cap_pe[1], cap_fe[1]} !== 2'b10) begin
      errors++; $display("FAIL parity_bad_flags: got %b want 10", {cap_pe[1], cap_fe[1]});
    end
    send_frame(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10, -1, -1, c0);
    idle(20);
    checks++;
    if (cap_data[1] !== 9'h041) begin
      errors++; $display("FAIL parity_good_data: got %h want 041", cap_data[1]);
    end
    checks++;
    if (cap_pe[1] !== 1'b0) begin
      errors++; $display("FAIL parity_good_flag: got %b want 0", cap_pe[1]);
    end
    checks++;
    if (rise_cnt[1] !== 2) begin
      errors++; $display("FAIL parity_deliveries: got %0d want 2", rise_cnt[1]);
    end
  endtask

  task automatic test_frame_err;
    int c0;
    bus_c.rx_data_ready = 1'b1;
    send_frame(2, {1'b0, 1'b1, 8'hC3, 1'b0}, 11, -1, -1, c0);
    idle(20);
    checks++;
    if (cap_data[2] !== 9'h0C3) begin
      errors++; $display("FAIL frame_bad_data: got %h want 0c3", cap_data[2]);
    end
    checks++;
    if ({cap_pe[2], cap_fe[2]} !== 2'b01) begin
      errors++; $display("FAIL frame_bad_flags: got %b want 01", {cap_pe[2], cap_fe[2]});
    end
    // pin fall + 3 + 10*8 + 3 + 1
    checks++;
    if (rise_cyc[2] - c0 !== 87) begin
      errors++; $display("FAIL frame_latency_2stop: got %0d want 87", rise_cyc[2] - c0);
    end
    send_frame(2, {1'b1, 1'b1, 8'h12, 1'b0}, 11, -1, -1, c0);
    idle(20);
    checks++;
    if (cap_data[2] !== 9'h012) begin
      errors++; $display("FAIL frame_good_data: got %h want 012", cap_data[2]);
    end
    checks++;
    if (cap_fe[2] !== 1'b0) begin
      errors++; $display("FAIL frame_good_flag: got %b want 0", cap_fe[2]);
    end
  endtask

  task automatic test_false_start;
    int r0, c0;
    r0 = rise_cnt[0];
    pin_a = 1'b0;
    idle(2);
    pin_a = 1'b1;
    idle(2);
    checks++;
    if (st_a !== 3'd1) begin
      errors++; $display("FAIL false_start_enters_start: got %0d want 1", st_a);
    end
    idle(60);
    checks++;
    if (st_a !== 3'd0) begin
      errors++; $display("FAIL false_start_back_idle: got %0d want 0", st_a);
    end
    checks++;
    if (rise_cnt[0] !== r0) begin
      errors++; $display("FAIL false_start_no_output: got %0d want %0d", rise_cnt[0], r0);
    end
    // one-clock glitch at the centre of data bit 3 (line bit 4, offset 4)
    send_frame(0, {1'b1, 8'h00, 1'b0}, 10, 36, -1, c0);
    idle(20);
    checks++;
    if (rise_cnt[0] - r0 !== 1) begin
      errors++; $display("FAIL glitch_deliveries: got %0d want 1", rise_cnt[0] - r0);
    end
    checks++;
    if ({cap_data[0], cap_fe[0]} !== 10'h000) begin
      errors++; $display("FAIL glitch_data: got %h want 000", {cap_data[0], cap_fe[0]});
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2, r0, o0, x0;
    bus_a.rx_data_ready = 1'b0;
    r0 = rise_cnt[0]; o0 = ovr_cnt[0]; x0 = xfer_cnt[0];
    send_frame(0, {1'b1, 8'hA5, 1'b0}, 10, -1, -1, c1);
    send_frame(0, {1'b1, 8'h3C, 1'b0}, 10, -1, -1, c2);
    idle(10);
    checks++;
    if (rise_cnt[0] - r0 !== 1) begin
      errors++; $display("FAIL b2b_one_load: got %0d want 1", rise_cnt[0] - r0);
    end
    checks++;
    if (bus_a.rx_data !== 8'hA5 || bus_a.rx_data_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_held_word: got %h/%b want a5/1", bus_a.rx_data, bus_a.rx_data_valid);
    end
    checks++;
    if (ovr_cnt[0] - o0 !== 1) begin
      errors++; $display("FAIL b2b_overrun_pulses: got %0d want 1", ovr_cnt[0] - o0);
    end
    checks++;
    if (ovr_cyc[0] - c2 !== 79) begin
      errors++; $display("FAIL b2b_overrun_time: got %0d want 79", ovr_cyc[0] - c2);
    end
    bus_a.rx_data_ready = 1'b1;
    idle(4);
    checks++;
    if (bus_a.rx_data_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_valid_falls: got %b want 0", bus_a.rx_data_valid);
    end
    checks++;
    if (xfer_cnt[0] - x0 !== 1) begin
      errors++; $display("FAIL b2b_transfers: got %0d want 1", xfer_cnt[0] - x0);
    end
  endtask

  task automatic test_reset_midframe;
    int c0, r0;
    bus_a.rx_data_ready = 1'b1;
    r0 = rise_cnt[0];
    // reset during data bit 4 of 0xF0; bits 4..7 and stop are 1, so no new edge
    send_frame(0, {1'b1, 8'hF0, 1'b0}, 10, -1, 44, c0);
    idle(20);
    checks++;
    if ({bus_a.rx_data, bus_a.rx_data_valid, bus_a.parity_err, bus_a.frame_err, bus_a.overrun} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 000",
               {bus_a.rx_data, bus_a.rx_data_valid, bus_a.parity_err, bus_a.frame_err, bus_a.overrun});
    end
    checks++;
    if (rise_cnt[0] !== r0) begin
      errors++; $display("FAIL midreset_no_delivery: got %0d want %0d", rise_cnt[0], r0);
    end
    checks++;
    if (st_a !== 3'd0) begin
      errors++; $display("FAIL midreset_state: got %0d want 0", st_a);
    end
    send_frame(0, {1'b1, 8'h7E, 1'b0}, 10, -1, -1, c0);
    idle(20);
    checks++;
    if (rise_cnt[0] - r0 !== 1 || cap_data[0] !== 9'h07E) begin
      errors++; $display("FAIL midreset_next_frame: got %0d/%h want 1/07e", rise_cnt[0] - r0, cap_data[0]);
    end
    checks++;
    if ({cap_pe[0], cap_fe[0]} !== 2'b00) begin
      errors++; $display("FAIL midreset_next_flags: got %b want 00", {cap_pe[0], cap_fe[0]});
    end
  endtask

  // sequence and report
  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    pin_a = 1'b1; pin_b = 1'b1; pin_c = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_parity;
    test_frame_err;
    test_false_start;
    test_back_to_back;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
